bep_encode_tx: RTL and testbench
================================

BEP_ENCODE_TX -- requirements
Module: bep_encode_tx

Interface
REQ-001 Parameter HALF_BIT_CYCLES, default 8, clk cycles per Manchester half-bit; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 tx_addr  input  4  destination address of the frame.
REQ-005 tx_data  input  8  payload byte.
REQ-006 tx_valid  input  1  frame request; held with addr/data until accepted.
REQ-007 tx_ready  output  1  high only in IDLE; a frame is accepted on tx_valid && tx_ready.
REQ-008 manchester_data  output  1  encoded line; low when idle.
REQ-009 manchester_clock  output  1  high during the second half of each transmitted bit, else low.
REQ-010 transmission_begin  output  1  one-cycle pulse on the first cycle of the preamble.
REQ-011 tx_active  output  1  high from the first preamble cycle through the last gap cycle.
REQ-012 tx_done  output  1  one-cycle pulse on the last gap cycle.

Function
REQ-013 Accepted tx_addr/tx_data SHALL be registered on the accept edge; later input changes have no effect on the frame in flight.
REQ-014 Frame order SHALL be PREAMBLE 8'b1010_1011, ADDR (4 b), DATA (8 b), [PARITY (1 b)], GAP; every field MSB first.
REQ-015 Encoding SHALL be: bit 1 = low then high, bit 0 = high then low; each half lasts exactly HALF_BIT_CYCLES cycles.
REQ-016 GAP SHALL hold manchester_data low for 2 bit times (4*HALF_BIT_CYCLES cycles); manchester_clock stays low.
REQ-017 States SHALL be IDLE -> PREAMBLE -> ADDR -> DATA -> [PARITY] -> GAP -> IDLE; each advance happens after the last half-bit of the field.
REQ-018 The first preamble half-bit SHALL appear on the cycle after the accept edge, and transmission_begin pulses on that cycle.
REQ-019 Frame length SHALL be 44*HALF_BIT_CYCLES cycles (46* with parity), measured from the first preamble cycle through the last gap cycle.
REQ-020 tx_ready SHALL rise on the cycle after tx_done; back-to-back frames start no earlier than that cycle.
REQ-021 tx_valid asserted outside IDLE SHALL be ignored (not queued).
REQ-022 The bit-phase and bit-index counters SHALL wrap cleanly at field boundaries, with no extra or short half-bits between fields.

Reset
REQ-023 With rst high at a clock edge, the block SHALL enter IDLE, clear the counters and registered fields, and drive manchester_data=0, manchester_clock=0, transmission_begin=0, tx_active=0, tx_done=0 and tx_ready=1 on the following cycle.
REQ-024 Reset mid-frame SHALL abort the frame immediately with no tx_done pulse; the line goes low.
REQ-025 tx_ready SHALL be 0 while rst is high.

Configuration
REQ-026 Macro BEP_TX_PARITY_EN defined: a PARITY bit SHALL be sent after DATA, equal to the XOR of the 12 addr+data bits (even parity).
REQ-027 Macro BEP_TX_PARITY_EN undefined: there SHALL be no PARITY state, and DATA goes directly to GAP.

Structure
REQ-028 Package bep_pkg SHALL hold the state enum, the BEP_PREAMBLE constant, the field widths (ADDR_W=4, DATA_W=8, PRE_W=8) and GAP_BITS=2.
REQ-029 Sub-module bep_bit_timer SHALL generate the half-bit strobe and the first/second-half phase from HALF_BIT_CYCLES, with a synchronous clear.

Verification
REQ-030 HALF_BIT_CYCLES=8, addr=4'hA, data=8'h3C, parity off -> decoded bits 1010_1011_1010_0011_1100; 352-cycle frame; tx_done 351 cycles after transmission_begin.
REQ-031 Parity on, addr=4'h1, data=8'h01 -> parity bit 0; addr=4'h1, data=8'h03 -> parity bit 1; frame length 368 cycles.
REQ-032 tx_valid held high continuously -> second transmission_begin exactly 2 cycles after the first tx_done, and tx_ready high for exactly one cycle between the frames.
REQ-033 tx_data changed from 8'h3C to 8'hFF one cycle after accept -> transmitted DATA field is still 0011_1100.
REQ-034 rst pulsed during the DATA field -> no tx_done; manchester_data=0 and tx_ready=1 on the cycle after the reset edge; a new frame after reset encodes correctly.
REQ-035 HALF_BIT_CYCLES=2, data=8'h00 -> every data bit is high 2 cycles then low 2 cycles; manchester_clock is high exactly during the second halves.

Source files
------------

// File: rtl/bep_pkg.sv
// Shared types and constants for the BEP Manchester frame transmitter.
// BEP_TX_PARITY_EN adds the PARITY state to the state enum.
package bep_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int PRE_W    = 8;
    localparam int GAP_BITS = 2;
    localparam int IDX_W    = 3;

    localparam logic [PRE_W-1:0] BEP_PREAMBLE = 8'b1010_1011;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_ADDR     = 3'd2,
        ST_DATA     = 3'd3,
`ifdef BEP_TX_PARITY_EN
        ST_PARITY   = 3'd4,
`endif
        ST_GAP      = 3'd5
    } bep_state_t;

    function automatic logic even_parity(input logic [ADDR_W-1:0] addr,
                                         input logic [DATA_W-1:0] data);
        return ^{addr, data};
    endfunction

endpackage

// File: rtl/bep_bit_timer.sv
// Half-bit timer: down-counter whose terminal count marks the last cycle of
// each half-bit; phase is 0 for the first half of a bit and 1 for the second.
module bep_bit_timer #(
    parameter int HALF_BIT_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic strobe,
    output logic phase
);

    localparam logic [7:0] CNT_TOP = 8'(HALF_BIT_CYCLES - 1);

    logic [7:0] cnt;

    assign strobe = (cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt   <= CNT_TOP;
            phase <= 1'b0;
        end else if (strobe) begin
            cnt   <= CNT_TOP;
            phase <= ~phase;
        end else begin
            cnt   <= cnt - 8'd1;
        end
    end

endmodule

// File: rtl/bep_encode_tx.sv
// BEP frame transmitter: preamble, address, data, optional parity (enabled by
// BEP_TX_PARITY_EN) and a low gap, Manchester encoded MSB first.
//
// state    | meaning
// IDLE     | line low, tx_ready high, waiting for tx_valid
// PREAMBLE | sending BEP_PREAMBLE
// ADDR     | sending latched address
// DATA     | sending latched payload
// PARITY   | sending even parity of addr+data (BEP_TX_PARITY_EN only)
// GAP      | line low for GAP_BITS bit times, tx_done on the last cycle
module bep_encode_tx
    import bep_pkg::*;
#(
    parameter int HALF_BIT_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] tx_addr,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              manchester_data,
    output logic              manchester_clock,
    output logic              transmission_begin,
    output logic              tx_active,
    output logic              tx_done
);

    bep_state_t        state, state_nxt;
    logic [IDX_W-1:0]  bit_idx, bit_idx_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              begin_q;
    logic              load;
    logic              cur_bit;
    logic              in_field;
    logic              strobe;
    logic              phase;
    logic              bit_end;
    logic              last_bit;

    // Timer is held at the start of a half-bit while idle, so the first
    // preamble half-bit is full length right after the accept edge.
    bep_bit_timer #(
        .HALF_BIT_CYCLES (HALF_BIT_CYCLES)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == ST_IDLE),
        .strobe (strobe),
        .phase  (phase)
    );

    assign bit_end  = strobe && phase;
    assign last_bit = bit_end && (bit_idx == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            begin_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_idx <= bit_idx_nxt;
            begin_q <= load;
            if (load) begin
                addr_q <= tx_addr;
                data_q <= tx_data;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        load        = 1'b0;
        cur_bit     = 1'b0;
        if (bit_end) begin
            bit_idx_nxt = bit_idx - 3'd1;
        end
        case (state)
            ST_IDLE: begin
                bit_idx_nxt = '0;
                if (tx_valid) begin
                    load        = 1'b1;
                    state_nxt   = ST_PREAMBLE;
                    bit_idx_nxt = 3'(PRE_W - 1);
                end
            end
            ST_PREAMBLE: begin
                cur_bit = BEP_PREAMBLE[bit_idx];
                if (last_bit) begin
                    state_nxt   = ST_ADDR;
                    bit_idx_nxt = 3'(ADDR_W - 1);
                end
            end
            ST_ADDR: begin
                cur_bit = addr_q[bit_idx[1:0]];
                if (last_bit) begin
                    state_nxt   = ST_DATA;
                    bit_idx_nxt = 3'(DATA_W - 1);
                end
            end
            ST_DATA: begin
                cur_bit = data_q[bit_idx];
                if (last_bit) begin
`ifdef BEP_TX_PARITY_EN
                    state_nxt   = ST_PARITY;
                    bit_idx_nxt = '0;
`else
                    state_nxt   = ST_GAP;
                    bit_idx_nxt = 3'(GAP_BITS - 1);
`endif
                end
            end
`ifdef BEP_TX_PARITY_EN
            ST_PARITY: begin
                cur_bit = even_parity(addr_q, data_q);
                if (last_bit) begin
                    state_nxt   = ST_GAP;
                    bit_idx_nxt = 3'(GAP_BITS - 1);
                end
            end
`endif
            ST_GAP: begin
                if (last_bit) begin
                    state_nxt   = ST_IDLE;
                    bit_idx_nxt = '0;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                bit_idx_nxt = '0;
            end
        endcase
    end

    // A one is low-then-high, a zero high-then-low.
    assign in_field           = (state != ST_IDLE) && (state != ST_GAP);
    assign manchester_data    = in_field && (phase ? cur_bit : ~cur_bit);
    assign manchester_clock   = in_field && phase;
    assign transmission_begin = begin_q;
    assign tx_active          = (state != ST_IDLE);
    assign tx_done            = (state == ST_GAP) && last_bit;
    assign tx_ready           = (state == ST_IDLE) && !rst;

endmodule

// File: tb/tb_bep_encode_tx.sv
// Scoreboard bench for bep_encode_tx: accepted frames are queued and a
// negedge monitor checks the line against a bit-list model of each frame.
module tb_bep_encode_tx;

    localparam int H  = 8;
    localparam int H2 = 2;
`ifdef BEP_TX_PARITY_EN
    localparam int NBITS = 21;
`else
    localparam int NBITS = 20;
`endif
    localparam int FLEN  = (NBITS * 2 + 4) * H;
    localparam int FLEN2 = (NBITS * 2 + 4) * H2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] tx_addr;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, manchester_data, manchester_clock;
    logic       transmission_begin, tx_active, tx_done;

    logic [3:0] a2;
    logic [7:0] d2;
    logic       v2;
    logic       ready2, md2, mc2, tb2, act2, done2;

    always #5 clk = ~clk;

    bep_encode_tx #(.HALF_BIT_CYCLES(H)) dut (
        .clk(clk), .rst(rst), .tx_addr(tx_addr), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready),
        .manchester_data(manchester_data), .manchester_clock(manchester_clock),
        .transmission_begin(transmission_begin), .tx_active(tx_active),
        .tx_done(tx_done)
    );

    bep_encode_tx #(.HALF_BIT_CYCLES(H2)) dut2 (
        .clk(clk), .rst(rst), .tx_addr(a2), .tx_data(d2),
        .tx_valid(v2), .tx_ready(ready2),
        .manchester_data(md2), .manchester_clock(mc2),
        .transmission_begin(tb2), .tx_active(act2), .tx_done(done2)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: frame as a list of bits, straight from the frame format.
    logic [11:0] exp_q[$];
    logic        bits[0:31];

    function automatic void build(input logic [11:0] fr);
        logic [7:0] pre;
        int n;
        pre = 8'b1010_1011;
        n = 0;
        for (int i = 7; i >= 0; i--) begin bits[n] = pre[i]; n++; end
        for (int i = 11; i >= 0; i--) begin bits[n] = fr[i]; n++; end
        if (NBITS == 21) bits[n] = ($countones(fr) % 2) == 1;
    endfunction

    bit mon_active = 0;
    bit done_seen;
    int mon_cyc, wave_err, idle_err = 0, frames_done = 0;

    always @(negedge clk) begin : monitor
        int  half;
        logic b, ed, ec;
        if (!rst && tx_valid && tx_ready) exp_q.push_back({tx_addr, tx_data});
        if (rst) begin
            mon_active = 0;
        end else begin
            if (!mon_active) begin
                if (transmission_begin) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_frame: got a frame start, required none queued");
                    end else begin
                        build(exp_q.pop_front());
                        mon_active = 1; mon_cyc = 0; wave_err = 0; done_seen = 0;
                    end
                end else if (manchester_data || manchester_clock || tx_active || tx_done || !tx_ready) begin
                    idle_err++;
                end
            end
            if (mon_active) begin
                half = mon_cyc / H;
                b = 1'b0; ed = 1'b0; ec = 1'b0;
                if (half < 2 * NBITS) begin
                    b  = bits[half / 2];
                    ec = (half % 2) == 1;
                    ed = ec ? b : !b;
                end
                if (manchester_data !== ed || manchester_clock !== ec || tx_active !== 1'b1 ||
                    tx_ready !== 1'b0 || transmission_begin !== (mon_cyc == 0))
                    wave_err++;
                if (half < 2 * NBITS && (mon_cyc % (2 * H)) == H + H / 2)
                    chk("decoded_bit", int'(manchester_data), int'(b));
                if (tx_done) begin
                    chk("done_latency", mon_cyc, FLEN - 1);
                    done_seen = 1;
                end
                mon_cyc++;
                if (mon_cyc == FLEN) begin
                    chk("frame_wave_errors", wave_err, 0);
                    chk("done_seen", int'(done_seen), 1);
                    mon_active = 0;
                    frames_done++;
                end
            end
        end
    end

    function automatic logic sig(input int sel);
        case (sel)
            0: return transmission_begin;
            1: return tx_done;
            2: return tx_ready;
            3: return tb2;
            4: return done2;
            default: return ready2;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int limit);
        bit ok;
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sig(sel)) begin ok = 1; break; end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL timeout: signal %0d not seen within %0d cycles", sel, limit);
        end
    endtask

    task automatic send(input logic [3:0] a, input logic [7:0] d, input bit change);
        @(posedge clk); #1;
        tx_addr = a; tx_data = d; tx_valid = 1'b1;
        wait_for(2, 2 * FLEN);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        if (change) tx_data = 8'hFF;
    endtask

    int expected_frames = 0;

    initial begin
        int gap, rc, dcnt;
        logic [7:0] bad2;
        rst = 1'b1; tx_addr = '0; tx_data = '0; tx_valid = 1'b0;
        a2 = '0; d2 = '0; v2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("ready_in_reset", int'(tx_ready), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", int'({manchester_data, manchester_clock, transmission_begin,
                                   tx_active, tx_done, tx_ready}), 1);

        send(4'hA, 8'h3C, 0); expected_frames++;
        wait_for(1, FLEN + 50);
        send(4'h1, 8'h01, 0); expected_frames++;
        send(4'h1, 8'h03, 0); expected_frames++;
        send(4'hA, 8'h3C, 1); expected_frames++;

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            send(4'($urandom), 8'($urandom), 0); expected_frames++;
            wait_for(0, 10);
            repeat ($urandom_range(10, 100)) @(negedge clk);
            @(posedge clk); #1;
            tx_valid = 1'b1; tx_addr = 4'($urandom); tx_data = 8'($urandom);
            repeat ($urandom_range(1, 50)) @(posedge clk);
            #1 tx_valid = 1'b0;
            wait_for(1, FLEN + 50);
        end

        // Back-to-back with tx_valid held high.
        @(posedge clk); #1;
        tx_addr = 4'h3; tx_data = 8'h5A; tx_valid = 1'b1;
        expected_frames += 2;
        wait_for(1, FLEN + 50);
        gap = 0; rc = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (tx_ready) rc++;
            if (transmission_begin) begin gap = k; break; end
        end
        chk("b2b_begin_gap", gap, 2);
        chk("b2b_ready_cycles", rc, 1);
        @(posedge clk); #1 tx_valid = 1'b0;
        wait_for(1, FLEN + 50);

        // Reset in the middle of the DATA field.
        send(4'h5, 8'h96, 0);
        wait_for(0, 10);
        repeat (12 * 2 * H + 3 * H) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_line_low", int'(manchester_data), 0);
        chk("abort_ready", int'(tx_ready), 1);
        chk("abort_active", int'(tx_active), 0);
        dcnt = 0;
        for (int k = 0; k < FLEN; k++) begin
            @(negedge clk);
            if (tx_done) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        send(4'hC, 8'hA5, 0); expected_frames++;
        wait_for(1, FLEN + 50);

        // Short half-bit instance, all-zero payload.
        @(posedge clk); #1;
        a2 = 4'h6; d2 = 8'h00; v2 = 1'b1;
        wait_for(5, 20);
        @(posedge clk); #1 v2 = 1'b0;
        wait_for(3, 10);
        bad2 = '0;
        for (int c = 1; c <= FLEN2 - 1; c++) begin
            @(negedge clk);
            if (c >= 48 && c < 80) begin
                if (md2 !== (((c - 48) % 4) < 2) || mc2 !== (((c - 48) % 4) >= 2))
                    bad2[(c - 48) / 4] = 1'b1;
            end
            if (c == FLEN2 - 1) chk("h2_done_cycle", int'(done2), 1);
        end
        for (int i = 0; i < 8; i++) chk("h2_data_bit_shape", int'(bad2[i]), 0);

        repeat (5) @(negedge clk);
        chk("idle_line_errors", idle_err, 0);
        chk("queue_empty", exp_q.size(), 0);
        chk("frames_completed", frames_done, expected_frames);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
